pic_cascade_seq: RTL
====================

# pic_cascade_seq

Parametrised, clocked INTA-sequence and cascade controller for the PIC. Sits between the priority resolver, the ICW registers and the data-bus buffer. It tracks CPU acknowledge pulses with a state machine, drives or decodes the cascade bus, and presents the interrupt vector on the correct pulse. It generalises channel count, and adds spurious-request handling, ISR-set strobes and an optional 8080 three-pulse mode.

## Interface
- N_CH, 8: request channels; power of two, 2..64.
- ID_W, $clog2(N_CH): cascade bus and slave-ID width.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inta_n  in  1  CPU acknowledge, active low, already synchronised to clk.
- sngl  in  1  1 = single PIC, 0 = cascaded.
- sp_en  in  1  1 = master, 0 = slave.
- icw2  in  8  vector base.
- icw3  in  N_CH  master: slave-present mask; slave: ID in [ID_W-1:0].
- irq_grant  in  N_CH  one-hot winning request from the priority resolver, or zero.
- cas_in  in  ID_W  cascade bus as received.
- cas_out  out  ID_W  cascade bus drive value.
- cas_oe  out  1  cascade bus drive enable (master only).
- vec_out  out  8  byte for the data buffer.
- vec_oe  out  1  data buffer drive enable.
- isr_set  out  N_CH  one-cycle one-hot strobe to the ISR.
- spurious  out  1  one-cycle strobe: no valid grant at acknowledge.
- mode_8086  in  1  present only with PIC_CASCADE_CALL3_EN; 1 = two-pulse mode, 0 = three-pulse mode.

## Operation
- Edge detect: inta_q registers inta_n (reset value 1). fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
- States: IDLE, P1 (first pulse low), G1 (gap), P2, G2 and P3 (G2 and P3 only with the macro).
- IDLE, on fall:
  - Latch idx = encode(irq_grant), and latch sngl, sp_en, icw2 and icw3.
  - If irq_grant is not exactly one-hot, set idx = N_CH-1, pulse spurious and suppress isr_set.
  - Otherwise pulse isr_set = irq_grant.
  - Go to P1.
- Transitions:
  - P1, on rise: go to G1.
  - G1, on fall: go to P2.
  - P2, on rise: go to IDLE. In three-pulse mode, go to G2 instead.
  - G2, on fall: go to P3.
  - P3, on rise: go to IDLE.
- A rise in IDLE is ignored. Changes on irq_grant or the ICWs after the first-pulse latch are ignored.
- Master cascade (sp_en=1, sngl=0, icw3[idx]=1):
  - cas_out = idx.
  - cas_oe high from the cycle after the P1 rise until the cycle after the final rise.
  - This device does not drive the vector.
- Slave select (sp_en=0, sngl=0): on the G1 fall, sel = (cas_in == icw3[ID_W-1:0]).
- Vector ownership: own = sngl | (sp_en & ~icw3[idx]) | (~sp_en & sel).
- Vector value: {icw2[7:ID_W], idx}.
- vec_oe is high in P2 (two-pulse mode) when own=1; it drops on the rise.
- Outputs are zero whenever not driven.

## Timing
- Reset values:
  - State IDLE.
  - cas_out=0, cas_oe=0, vec_out=0, vec_oe=0, isr_set=0, spurious=0.
- isr_set and spurious are asserted in the cycle after the first-pulse fall, for exactly one cycle.
- vec_oe and vec_out are valid one cycle after the P2 fall. They clear one cycle after the P2 rise.
- cas_oe latency is one cycle after the P1 rise, matching the trailing-edge rule.
- A fall and rise cannot occur in the same cycle. A glitch shorter than one clk is invisible.
- Reset asserted mid-sequence forces IDLE and all outputs low immediately. The next fall starts a new sequence.

## Configuration
- PIC_CASCADE_CALL3_EN defined:
  - Adds mode_8086 and states G2/P3.
  - With mode_8086=0, P1 drives vec_out=8'hCD (CALL), P2 drives {icw2[7:ID_W], idx}, and P3 drives icw2.
  - vec_oe gating by own is unchanged. A master with a slave on idx does not drive P1, P2 or P3.
- Undefined: two-pulse mode only; no mode_8086 port; P1 never drives the bus.

## Structure
- Shared package pic_pkg holds:
  - the state enum (IDLE, P1, G1, P2, G2, P3);
  - the constant CALL_OPCODE = 8'hCD;
  - the function onehot_encode returning {valid, idx}.
- One sub-module, pic_inta_edge: inta_n register plus fall/rise outputs.

## Test plan
- Single PIC, icw2=8'h40, irq_grant=8'h08, two-pulse mode:
  - isr_set=8'h08 after the first fall.
  - vec_out=8'h43 with vec_oe in P2; no cas_oe.
- Master, sngl=0, icw3=8'h04, irq_grant=8'h04:
  - cas_out=3'd2 with cas_oe from P1 rise+1 to P2 rise+1.
  - vec_oe never high.
- Slave with ID 3, icw2=8'h70, irq_grant=8'h20:
  - cas_in=3 at G1 fall gives vec_out=8'h75.
  - cas_in=5 leaves vec_oe low throughout.
- irq_grant=8'h00 at first fall:
  - spurious pulses for one cycle; isr_set stays 0.
  - Vector in P2 is {icw2[7:3], 3'd7}.
- rst_n pulsed low during G1:
  - All outputs 0 immediately.
  - Next full sequence completes normally.
- With PIC_CASCADE_CALL3_EN, mode_8086=0, single PIC, icw2=8'h12, irq_grant=8'h01:
  - Bytes 8'hCD, 8'h10 and 8'h12 appear on P1, P2 and P3 respectively.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC INTA-sequence / cascade controller.
package pic_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        G1   = 3'd2,
        P2   = 3'd3,
        G2   = 3'd4,
        P3   = 3'd5
    } pic_state_e;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    // Returns {valid, idx}; valid only when exactly one bit of vec is set.
    function automatic logic [6:0] onehot_encode(input logic [63:0] vec);
        logic [5:0] idx;
        logic [6:0] cnt;
        idx = 6'd0;
        cnt = 7'd0;
        for (int i = 0; i < 64; i++) begin
            if (vec[i]) begin
                idx = 6'(i);
                cnt = cnt + 7'd1;
            end
        end
        return {(cnt == 7'd1), idx};
    endfunction

endpackage

// File: rtl/pic_inta_edge.sv
// Registers the (already synchronised) INTA strobe and reports its edges.
module pic_inta_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic inta_n,
    output logic fall,
    output logic rise
);

    logic inta_q_r;

    // Previous-cycle copy of inta_n; idles high like the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_q_r <= 1'b1;
        end else begin
            inta_q_r <= inta_n;
        end
    end

    assign fall = inta_q_r & ~inta_n;
    assign rise = ~inta_q_r & inta_n;

endmodule

// File: rtl/pic_cascade_seq.sv
// INTA-sequence and cascade controller. Define PIC_CASCADE_CALL3_EN to add the
// 8080 three-pulse (CALL) mode and the mode_8086 input.
module pic_cascade_seq
    import pic_pkg::*;
#(
    parameter int N_CH = 8,
    parameter int ID_W = $clog2(N_CH)
) (
`ifdef PIC_CASCADE_CALL3_EN
    input  logic            mode_8086,
`endif
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inta_n,
    input  logic            sngl,
    input  logic            sp_en,
    input  logic [7:0]      icw2,
    input  logic [N_CH-1:0] icw3,
    input  logic [N_CH-1:0] irq_grant,
    input  logic [ID_W-1:0] cas_in,
    output logic [ID_W-1:0] cas_out,
    output logic            cas_oe,
    output logic [7:0]      vec_out,
    output logic            vec_oe,
    output logic [N_CH-1:0] isr_set,
    output logic            spurious
);

    pic_state_e      state_r;
    logic [ID_W-1:0] idx_r;
    logic            sngl_r;
    logic            sp_en_r;
    logic [7:0]      icw2_r;
    logic [N_CH-1:0] icw3_r;
    logic            sel_r;
    logic            three_pulse_r;

    logic            fall_s;
    logic            rise_s;
    logic [63:0]     grant_ext_s;
    logic [6:0]      enc_s;
    logic [ID_W-1:0] grant_idx_s;
    logic            three_req_s;
    logic            own_p1_s;
    logic            sel_next_s;
    logic            own_p2_s;
    logic            own_p3_s;
    logic            cas_on_s;
    logic [7:0]      vec_s;

    pic_inta_edge u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .inta_n (inta_n),
        .fall   (fall_s),
        .rise   (rise_s)
    );

    // Widen the grant so the fixed-width package encoder serves any N_CH.
    always_comb begin
        grant_ext_s              = 64'd0;
        grant_ext_s[N_CH-1:0]    = irq_grant;
    end

    assign enc_s       = onehot_encode(grant_ext_s);
    assign grant_idx_s = enc_s[6] ? ID_W'(enc_s[5:0]) : ID_W'(N_CH - 1);

`ifdef PIC_CASCADE_CALL3_EN
    assign three_req_s = ~mode_8086;
`else
    assign three_req_s = 1'b0;
`endif

    // Ownership terms per phase; P1 uses live inputs because nothing is latched yet.
    always_comb begin
        own_p1_s   = sngl | (sp_en & ~icw3[grant_idx_s]);
        sel_next_s = ~sp_en_r & ~sngl_r & (cas_in == icw3_r[ID_W-1:0]);
        own_p2_s   = sngl_r | (sp_en_r & ~icw3_r[idx_r]) | (~sp_en_r & sel_next_s);
        own_p3_s   = sngl_r | (sp_en_r & ~icw3_r[idx_r]) | (~sp_en_r & sel_r);
        cas_on_s   = sp_en_r & ~sngl_r & icw3_r[idx_r];
        vec_s      = icw2_r;
        vec_s[ID_W-1:0] = idx_r;
    end

    // Acknowledge sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            idx_r         <= '0;
            sngl_r        <= 1'b0;
            sp_en_r       <= 1'b0;
            icw2_r        <= 8'd0;
            icw3_r        <= '0;
            sel_r         <= 1'b0;
            three_pulse_r <= 1'b0;
            cas_out       <= '0;
            cas_oe        <= 1'b0;
            vec_out       <= 8'd0;
            vec_oe        <= 1'b0;
            isr_set       <= '0;
            spurious      <= 1'b0;
        end else begin
            isr_set  <= '0;
            spurious <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (fall_s) begin
                        idx_r         <= grant_idx_s;
                        sngl_r        <= sngl;
                        sp_en_r       <= sp_en;
                        icw2_r        <= icw2;
                        icw3_r        <= icw3;
                        sel_r         <= 1'b0;
                        three_pulse_r <= three_req_s;
                        if (enc_s[6]) begin
                            isr_set <= irq_grant;
                        end else begin
                            spurious <= 1'b1;
                        end
                        if (three_req_s && own_p1_s) begin
                            vec_oe  <= 1'b1;
                            vec_out <= CALL_OPCODE;
                        end
                        state_r <= P1;
                    end
                end
                P1: begin
                    if (rise_s) begin
                        vec_oe  <= 1'b0;
                        vec_out <= 8'd0;
                        cas_oe  <= cas_on_s;
                        cas_out <= cas_on_s ? idx_r : '0;
                        state_r <= G1;
                    end
                end
                G1: begin
                    if (fall_s) begin
                        sel_r   <= sel_next_s;
                        vec_oe  <= own_p2_s;
                        vec_out <= own_p2_s ? vec_s : 8'd0;
                        state_r <= P2;
                    end
                end
                P2: begin
                    if (rise_s) begin
                        vec_oe  <= 1'b0;
                        vec_out <= 8'd0;
                        if (three_pulse_r) begin
                            state_r <= G2;
                        end else begin
                            cas_oe  <= 1'b0;
                            cas_out <= '0;
                            state_r <= IDLE;
                        end
                    end
                end
                G2: begin
                    if (fall_s) begin
                        vec_oe  <= own_p3_s;
                        vec_out <= own_p3_s ? icw2_r : 8'd0;
                        state_r <= P3;
                    end
                end
                P3: begin
                    if (rise_s) begin
                        vec_oe  <= 1'b0;
                        vec_out <= 8'd0;
                        cas_oe  <= 1'b0;
                        cas_out <= '0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
